// File: rtl/stream_serializer_if.sv
// Handshake bundle for stream_serializer: wide word in, narrow elements out.
interface stream_serializer_if #(
   parameter int DataBits = 8,
   parameter int Ratio    = 4,
   parameter int LenBits  = 3
);
   logic                      in_valid;
   logic                      in_ready;
   logic [Ratio*DataBits-1:0] in_data;
   logic [LenBits-1:0]        in_len;
   logic                      out_valid;
   logic                      out_ready;
   logic [DataBits-1:0]       out_data;
   logic                      out_last;

   modport master (
      output in_valid, in_data, in_len, out_ready,
      input  in_ready, out_valid, out_data, out_last
   );

   modport slave (
      input  in_valid, in_data, in_len, out_ready,
      output in_ready, out_valid, out_data, out_last
   );
endinterface

// File: rtl/stream_serializer.sv
// Wide-to-narrow serializer, LSB element first, with length field and out_last.
// STREAM_SERIALIZER_REG_OUT_EN adds a 2-entry registered skid stage on the output.
module stream_serializer #(
   parameter int DataBits = 8,
   parameter int Ratio    = 4,
   parameter int LenBits  = 3
) (
   input  logic               clk,
   input  logic               rst,
   stream_serializer_if.slave bus
);
   localparam int IdxW = $clog2(Ratio);

   typedef enum logic {EMPTY = 1'b0, SEND = 1'b1} state_t;

   state_t                          state, state_n;
   logic [Ratio-1:0][DataBits-1:0]  data_r, data_n;
   logic [IdxW-1:0]                 idx, idx_n;
   logic [LenBits-1:0]              len_r, len_n, eff_len;
   logic                            busy, in_xfer, c_xfer;
   logic                            c_valid, c_ready, c_last;
   logic [DataBits-1:0]             c_data;

   // Zero or oversized lengths mean a full word.
   assign eff_len = (bus.in_len == '0 || bus.in_len > LenBits'(Ratio)) ? LenBits'(Ratio) : bus.in_len;

   assign busy         = (state == SEND);
   assign c_valid      = busy;
   assign c_last       = busy && (LenBits'(idx) == len_r - LenBits'(1));
   assign c_data       = busy ? data_r[idx] : '0;
   assign bus.in_ready = busy ? (c_last & c_ready) : 1'b1;
   assign in_xfer      = bus.in_valid & bus.in_ready;
   assign c_xfer       = c_valid & c_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= EMPTY;
         data_r <= '0;
         idx    <= '0;
         len_r  <= '0;
      end else begin
         state  <= state_n;
         data_r <= data_n;
         idx    <= idx_n;
         len_r  <= len_n;
      end
   end

   always_comb begin
      state_n = state;
      data_n  = data_r;
      idx_n   = idx;
      len_n   = len_r;
      case (state)
         EMPTY: begin
            if (in_xfer) begin
               data_n  = bus.in_data;
               len_n   = eff_len;
               idx_n   = '0;
               state_n = SEND;
            end
         end
         SEND: begin
            if (c_xfer) begin
               if (!c_last) begin
                  idx_n = idx + IdxW'(1);
               end else if (in_xfer) begin
                  // Last element leaves while the next word arrives: no bubble.
                  data_n = bus.in_data;
                  len_n  = eff_len;
                  idx_n  = '0;
               end else begin
                  idx_n   = '0;
                  state_n = EMPTY;
               end
            end
         end
         default: state_n = EMPTY;
      endcase
   end

`ifdef STREAM_SERIALIZER_REG_OUT_EN
   logic                o_valid, o_last, s_valid, s_last, push;
   logic [DataBits-1:0] o_data, s_data;

   // Ready toward the core depends only on the skid flop, cutting the out_ready path.
   assign c_ready = !s_valid;
   assign push    = c_valid & c_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         o_valid <= 1'b0;
         o_data  <= '0;
         o_last  <= 1'b0;
         s_valid <= 1'b0;
         s_data  <= '0;
         s_last  <= 1'b0;
      end else if (!o_valid || bus.out_ready) begin
         if (s_valid) begin
            o_valid <= 1'b1;
            o_data  <= s_data;
            o_last  <= s_last;
            s_valid <= 1'b0;
            s_data  <= '0;
            s_last  <= 1'b0;
         end else begin
            o_valid <= push;
            o_data  <= push ? c_data : '0;
            o_last  <= push & c_last;
         end
      end else if (push) begin
         s_valid <= 1'b1;
         s_data  <= c_data;
         s_last  <= c_last;
      end
   end

   assign bus.out_valid = o_valid;
   assign bus.out_data  = o_data;
   assign bus.out_last  = o_last;
`else
   assign c_ready       = bus.out_ready;
   assign bus.out_valid = c_valid;
   assign bus.out_data  = c_data;
   assign bus.out_last  = c_last;
`endif
endmodule
